// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/half/word load or store per request over a
// req/ack data-memory port, with lane alignment, load extension and fault detection.
module load_store_unit #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 Valid_i,
   output logic                 Ready_o,
   input  logic                 MemRead_i,
   input  logic                 MemWrite_i,
   input  logic [2:0]           Funct3_i,
   input  logic [DATAWIDTH-1:0] ALUResult_i,
   input  logic [DATAWIDTH-1:0] WriteData_i,
   output logic [DATAWIDTH-1:0] ReadData_o,
   output logic                 WbValid_o,
   output logic                 Fault_o,
   output logic                 MemReq_o,
   output logic                 MemWe_o,
   output logic [DATAWIDTH-1:0] MemAddr_o,
   output logic [3:0]           MemBe_o,
   output logic [DATAWIDTH-1:0] MemWdata_o,
   input  logic                 MemAck_i,
   input  logic [DATAWIDTH-1:0] MemRdata_i
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t               state_q, state_d;
   logic                 we_q, we_d;
   logic [DATAWIDTH-1:0] addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic [DATAWIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]           lane_q, lane_d;
   logic [2:0]           f3_q, f3_d;
   logic [DATAWIDTH-1:0] rdata_q, rdata_d;
   logic                 fault_q, fault_d;

   logic                 illegal_f3;
   logic                 misaligned;
   logic [3:0]           req_be;
   logic [DATAWIDTH-1:0] req_wdata;
   logic [DATAWIDTH-1:0] load_ext;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;

   // Request decode: Funct3_i[1:0] encodes size (00 byte, 01 half, 10 word).
   always_comb begin
      illegal_f3 = 1'b0;
      misaligned = 1'b0;
      req_be     = 4'b0000;
      req_wdata  = WriteData_i;
      if (MemRead_i)
         illegal_f3 = (Funct3_i == 3'b011) || (Funct3_i[2:1] == 2'b11);
      else
         illegal_f3 = Funct3_i[2] || (Funct3_i[1:0] == 2'b11);
      case (Funct3_i[1:0])
         2'b00: begin
            req_be    = 4'b0001 << ALUResult_i[1:0];
            req_wdata = {4{WriteData_i[7:0]}};
         end
         2'b01: begin
            misaligned = ALUResult_i[0];
            req_be     = 4'b0011 << {ALUResult_i[1], 1'b0};
            req_wdata  = {2{WriteData_i[15:0]}};
         end
         default: begin
            misaligned = (ALUResult_i[1:0] != 2'b00);
            req_be     = 4'b1111;
         end
      endcase
   end

   always_comb begin
      case (lane_q)
         2'b00:   ld_byte = MemRdata_i[7:0];
         2'b01:   ld_byte = MemRdata_i[15:8];
         2'b10:   ld_byte = MemRdata_i[23:16];
         default: ld_byte = MemRdata_i[31:24];
      endcase
      ld_half = lane_q[1] ? MemRdata_i[31:16] : MemRdata_i[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'd0, ld_byte};
         3'b101:  load_ext = {16'd0, ld_half};
         default: load_ext = MemRdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      lane_d  = lane_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: begin
            if (Valid_i && (MemRead_i || MemWrite_i)) begin
               if ((MemRead_i && MemWrite_i) || illegal_f3 || misaligned) begin
                  // Faults skip the memory and report straight from DONE.
                  state_d = DONE;
                  fault_d = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = WAIT;
                  we_d    = MemWrite_i;
                  addr_d  = {ALUResult_i[DATAWIDTH-1:2], 2'b00};
                  be_d    = MemWrite_i ? req_be : 4'b0000;
                  wdata_d = MemWrite_i ? req_wdata : '0;
                  lane_d  = ALUResult_i[1:0];
                  f3_d    = Funct3_i;
               end
            end
         end
         WAIT: begin
            if (MemAck_i) begin
               state_d = DONE;
               fault_d = 1'b0;
               rdata_d = we_q ? '0 : load_ext;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         lane_q  <= 2'b00;
         f3_q    <= 3'b000;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         lane_q  <= lane_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign Ready_o    = (state_q == IDLE) && !rst_i;
   assign MemReq_o   = (state_q == WAIT);
   assign WbValid_o  = (state_q == DONE);
   assign MemWe_o    = we_q;
   assign MemAddr_o  = addr_q;
   assign MemBe_o    = be_q;
   assign MemWdata_o = wdata_q;
   assign ReadData_o = rdata_q;
   assign Fault_o    = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// reset/ignore sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, rd, wr, ack;
   logic [2:0]  f3;
   logic [31:0] addr, wd, mrd;
   logic        ready, wbv, fault, mreq, mwe;
   logic [31:0] rdata, maddr, mwdata;
   logic [3:0]  mbe;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATAWIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .Valid_i(valid), .Ready_o(ready),
      .MemRead_i(rd), .MemWrite_i(wr), .Funct3_i(f3),
      .ALUResult_i(addr), .WriteData_i(wd), .ReadData_o(rdata),
      .WbValid_o(wbv), .Fault_o(fault), .MemReq_o(mreq), .MemWe_o(mwe),
      .MemAddr_o(maddr), .MemBe_o(mbe), .MemWdata_o(mwdata),
      .MemAck_i(ack), .MemRdata_i(mrd)
   );

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, mrd;
      int          delay;
      logic        fault;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] wdata;
   } vec_t;

   typedef struct {
      logic        fault;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour expressed in byte arithmetic rather than lanes/muxes.
   function automatic exp_t model(input logic r, input logic w, input logic [2:0] fn,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] m);
      exp_t        e;
      int          nbytes, ofs;
      logic        legal;
      logic [31:0] mask, v;
      e.fault = 1'b0; e.rdata = 0; e.be = 0; e.wdata = 0;
      ofs = int'(a % 4);
      if (r && w) legal = 1'b0;
      else if (r) legal = (fn == 0 || fn == 1 || fn == 2 || fn == 4 || fn == 5);
      else        legal = (fn == 0 || fn == 1 || fn == 2);
      nbytes = (fn % 4 == 0) ? 1 : (fn % 4 == 1) ? 2 : 4;
      if (!legal || (ofs % nbytes) != 0) begin
         e.fault = 1'b1;
         return e;
      end
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
      if (w) begin
         e.be    = 4'((( 1 << nbytes) - 1) << ofs);
         e.wdata = (nbytes == 1) ? (d & 32'hFF) * 32'h0101_0101 :
                   (nbytes == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
      end else begin
         v = (m >> (8 * ofs)) & mask;
         if (fn < 4 && nbytes < 4 && v >= (mask + 1) / 2) v = v | ~mask;
         e.rdata = v;
      end
      return e;
   endfunction

   task automatic run_access(input logic r, input logic w, input logic [2:0] fn,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] m, input int delay, input exp_t e);
      chk("ready_before", 32'(ready), 32'd1);
      valid = 1'b1; rd = r; wr = w; f3 = fn; addr = a; wd = d;
      tick();
      valid = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'($urandom); addr = $urandom; wd = $urandom;
      if (!r && !w) begin
         chk("noop_ready", 32'(ready), 32'd1);
         chk("noop_req", 32'(mreq), 32'd0);
         chk("noop_wb", 32'(wbv), 32'd0);
         return;
      end
      if (!e.fault) begin
         for (int i = 0; i <= delay; i++) begin
            chk("wait_req", 32'(mreq), 32'd1);
            chk("wait_we", 32'(mwe), 32'(w));
            chk("wait_addr", maddr, {a[31:2], 2'b00});
            chk("wait_be", 32'(mbe), 32'(e.be));
            if (w) chk("wait_wdata", mwdata, e.wdata);
            chk("wait_ready", 32'(ready), 32'd0);
            chk("wait_wb", 32'(wbv), 32'd0);
            if (i == delay) begin
               ack = 1'b1; mrd = m; valid = 1'b0;
            end else begin
               ack = 1'b0; mrd = $urandom; valid = 1'b1; rd = 1'b1;
            end
            tick();
            rd = 1'b0;
         end
         ack = 1'b0; valid = 1'b0; mrd = $urandom;
      end
      chk("done_wb", 32'(wbv), 32'd1);
      chk("done_fault", 32'(fault), 32'(e.fault));
      chk("done_rdata", rdata, e.rdata);
      chk("done_req", 32'(mreq), 32'd0);
      tick();
      chk("after_wb", 32'(wbv), 32'd0);
      chk("after_ready", 32'(ready), 32'd1);
      chk("after_req", 32'(mreq), 32'd0);
   endtask

   vec_t vecs[$];
   exp_t ex;

   initial begin
      rst = 1'b1; valid = 0; rd = 0; wr = 0; f3 = 0; addr = 0; wd = 0; ack = 0; mrd = 0;
      // rd, wr, f3, addr, wdata, mem rdata, delay | fault, rdata, be, wdata
      vecs.push_back('{0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 0, 32'h0, 4'b1100, 32'hABCD_ABCD});
      vecs.push_back('{1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 0, 32'h0000_0080, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h8001_0000, 2, 0, 32'h0000_8001, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h8001_0000, 0, 0, 32'h8001_0000, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{1, 1, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{0, 1, 3'b000, 32'h0000_1001, 32'h1234_56A5, 32'h0, 3, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5});
      vecs.push_back('{0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF});
      vecs.push_back('{1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{0, 1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b001, 32'h0000_0005, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{0, 1, 3'b001, 32'h0000_0007, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b100, 32'h0000_0002, 32'h0, 32'h00AB_0000, 0, 0, 32'h0000_00AB, 4'b0000, 32'h0});
      vecs.push_back('{1, 0, 3'b000, 32'h0000_0000, 32'h0, 32'hFFFF_FF7F, 0, 0, 32'h0000_007F, 4'b0000, 32'h0});
      vecs.push_back('{0, 1, 3'b001, 32'h0000_0000, 32'h0000_1357, 32'h0, 0, 0, 32'h0, 4'b0011, 32'h1357_1357});

      tick(); tick();
      chk("rst_req", 32'(mreq), 32'd0);
      chk("rst_wb", 32'(wbv), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_be", 32'(mbe), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_ready", 32'(ready), 32'd1);

      foreach (vecs[k]) begin
         ex.fault = vecs[k].fault; ex.rdata = vecs[k].rdata;
         ex.be = vecs[k].be; ex.wdata = vecs[k].wdata;
         $display("vec %0d: rd=%0b wr=%0b f3=%03b addr=%h", k, vecs[k].rd, vecs[k].wr,
                  vecs[k].f3, vecs[k].addr);
         run_access(vecs[k].rd, vecs[k].wr, vecs[k].f3, vecs[k].addr, vecs[k].wd,
                    vecs[k].mrd, vecs[k].delay, ex);
      end

      // Request with neither read nor write is dropped.
      $display("noop request");
      ex = model(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
      run_access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 0, ex);

      // Reset while waiting for ack; a late ack must not complete anything.
      $display("reset mid-access");
      valid = 1'b1; rd = 1'b1; f3 = 3'b010; addr = 32'h40;
      tick();
      valid = 1'b0; rd = 1'b0;
      chk("mid_req_pre", 32'(mreq), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_req_rst", 32'(mreq), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_ready", 32'(ready), 32'd1);
      ack = 1'b1; mrd = 32'h1111_2222;
      tick();
      ack = 1'b0;
      chk("mid_wb", 32'(wbv), 32'd0);
      chk("mid_req", 32'(mreq), 32'd0);
      tick();
      chk("mid_wb2", 32'(wbv), 32'd0);
      chk("mid_ready2", 32'(ready), 32'd1);

      for (int n = 0; n < 80; n++) begin
         logic        rr, ww;
         logic [2:0]  ff;
         logic [31:0] aa, dd, mm;
         int          dl;
         rr = 1'($urandom); ww = 1'($urandom);
         if ($urandom_range(0, 3) != 0) ww = ~rr;
         ff = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         if (rr && !ww && $urandom_range(0, 2) == 0) ff[2] = 1'b1;
         aa = $urandom; dd = $urandom; mm = $urandom;
         dl = $urandom_range(0, 3);
         ex = model(rr, ww, ff, aa, dd, mm);
         $display("rand %0d: rd=%0b wr=%0b f3=%03b addr=%h delay=%0d exp_fault=%0b exp_rdata=%h",
                  n, rr, ww, ff, aa, dl, ex.fault, ex.rdata);
         run_access(rr, ww, ff, aa, dd, mm, dl, ex);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
